gyro_spi_reader: RTL and testbench
==================================

GYRO_SPI_READER -- requirements
Module: gyro_spi_reader

Parameters
REQ-001 The block SHALL have parameter CLK_DIV, default 50, meaning system clocks per SCLK half-period (100 MHz clk gives 1 MHz SCLK).
REQ-002 The block SHALL have parameter POLL_CYCLES, default 1000000, meaning clocks from one sample publish to the next read start (10 ms).
REQ-003 The block SHALL have parameter CFG_BYTE, default 8'h0F, meaning value written to gyro CTRL_REG1 (0x20): normal mode, X/Y/Z enabled.

Interface
REQ-004 The block SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit: enables polling; sampled only at transaction boundaries.
REQ-007 The block SHALL have port miso, input, 1 bit: serial data from PmodGyro.
REQ-008 The block SHALL have port sclk, output, 1 bit: SPI clock, mode 3 (idles high).
REQ-009 The block SHALL have port mosi, output, 1 bit: serial data to PmodGyro.
REQ-010 The block SHALL have port ss, output, 1 bit: active-low chip select.
REQ-011 The block SHALL have ports xAxis_gyro, yAxis_gyro and zAxis_gyro, each output, 16 bits: last published signed angular rate per axis.
REQ-012 The block SHALL have port data_valid, output, 1 bit: one-clock pulse when the axis outputs update.
REQ-013 The block SHALL have port busy, output, 1 bit: high while ss is low or during setup/hold.

Function
REQ-014 States SHALL be CFG, CFG_GAP, IDLE, READ, PUBLISH and WAIT; reset enters CFG.
REQ-015 CFG: one 2-byte transaction SHALL send 8'h20 then CFG_BYTE, performed once per reset regardless of en.
REQ-016 CFG_GAP: ss SHALL stay high 2*CLK_DIV clocks, then go to IDLE.
REQ-017 IDLE: go to READ when en=1, else remain.
REQ-018 READ: one 7-byte transaction SHALL send 8'hE8 (read, auto-increment, addr 0x28) then six 8'h00 bytes while capturing six MISO bytes X_L, X_H, Y_L, Y_H, Z_L, Z_H.
REQ-019 Transaction timing: ss falls, CLK_DIV clocks setup, then per bit sclk low CLK_DIV clocks and high CLK_DIV clocks; after the final rising edge, CLK_DIV clocks hold, then ss rises.
REQ-020 Bit order SHALL be MSB first, 8*N bits with no inter-byte gap; mosi changes only on sclk falling edges (first bit valid at ss fall); miso sampled in the clk cycle sclk rises.
REQ-021 PUBLISH (one clock): xAxis_gyro={X_H,X_L}, yAxis_gyro={Y_H,Y_L} and zAxis_gyro={Z_H,Z_L} SHALL update simultaneously with data_valid=1, then go to WAIT.
REQ-022 Outputs SHALL hold their values between publishes; partial captures are never visible.
REQ-023 WAIT: count POLL_CYCLES clocks, then go to READ if en=1, else to IDLE.
REQ-024 en deasserted mid-READ SHALL NOT abort; the transaction completes and publishes.
REQ-025 Counters SHALL be sized from parameters; no wrap within a transaction; POLL_CYCLES>=1 and CLK_DIV>=1 supported.

Reset
REQ-026 While rst=0, asynchronously: ss=1, sclk=1, mosi=0, busy=0, data_valid=0, all axis outputs=16'h0000, counters cleared, state=CFG.
REQ-027 Reset asserted mid-transaction SHALL abort immediately with no publish; on release the block re-runs CFG.
REQ-028 First ss fall SHALL occur on the first clk edge after rst releases.

Verification
REQ-029 CLK_DIV=2, en=1, slave model: after reset, first transaction is 16 bits with MOSI 8'h20, 8'h0F; ss low exactly 2+16*4+2 clocks.
REQ-030 Slave returns 34 12 CD AB 00 80 -> x=16'h1234, y=16'hABCD, z=16'h8000, single data_valid pulse, mosi byte0=8'hE8.
REQ-031 POLL_CYCLES=10, en held 1 -> publish-to-next-ss-fall gap equals 10 clocks + 1; three consecutive samples published correctly.
REQ-032 en dropped during READ byte 3 -> transaction completes, publishes, then block idles with ss=1; en re-raised -> READ starts next clock.
REQ-033 rst pulsed low during READ byte 4 -> ss=1 and sclk=1 within the reset, outputs 0, no data_valid, CFG re-sent after release.
REQ-034 sclk checks throughout: idle high whenever ss=1, mosi stable across each rising edge, no sclk edge within CLK_DIV of an ss edge.

Source files
------------

// File: rtl/gyro_spi_reader.sv
// PmodGyro SPI reader: writes CTRL_REG1 once after reset, then polls the
// six X/Y/Z rate registers with one burst read and publishes all three axes
// together. SPI mode 3 (sclk idles high), MSB first.
//
// Handshake: data_valid is a one-clock strobe with no ready; the axis
// outputs are valid whenever data_valid is high and hold until the next
// strobe.
module gyro_spi_reader #(
  parameter int         CLK_DIV     = 50,
  parameter int         POLL_CYCLES = 1000000,
  parameter logic [7:0] CFG_BYTE    = 8'h0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        ss,
  output logic [15:0] xAxis_gyro,
  output logic [15:0] yAxis_gyro,
  output logic [15:0] zAxis_gyro,
  output logic        data_valid,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_CYCLES = 2 * CLK_DIV;
  localparam int CNT_MAX    = (POLL_CYCLES > GAP_CYCLES) ? POLL_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_CFG     = 3'd0,
    S_CFG_GAP = 3'd1,
    S_IDLE    = 3'd2,
    S_READ    = 3'd3,
    S_PUBLISH = 3'd4,
    S_WAIT    = 3'd5
  } state_t;

  // Phases of one ss-low transaction; OFF means ss is high.
  typedef enum logic [2:0] {
    PH_OFF   = 3'd0,
    PH_SETUP = 3'd1,
    PH_LOW   = 3'd2,
    PH_HIGH  = 3'd3,
    PH_HOLD  = 3'd4
  } phase_t;

  state_t      state, state_next;
  phase_t      phase;
  logic [DIV_W-1:0] div_cnt;
  logic [5:0]  bit_cnt;
  logic [CNT_W-1:0] cnt;
  logic [55:0] tx_sh;
  logic [47:0] rx_sh;
  logic        div_last;
  logic        bit_last;
  logic        xfer_done;
  logic        xfer_start;
  logic [55:0] tx_load;

  assign div_last  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign bit_last  = (bit_cnt == ((state == S_CFG) ? 6'd15 : 6'd55));
  assign xfer_done = (phase == PH_HOLD) && div_last;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_CFG;
    else      state <= state_next;
  end

  // Next state, plus the transaction launch decided on entry to CFG/READ so
  // ss falls on the same edge the FSM enters the transfer state.
  always_comb begin
    state_next = state;
    xfer_start = 1'b0;
    tx_load    = {8'hE8, 48'h0};
    case (state)
      S_CFG:     if (xfer_done) state_next = S_CFG_GAP;
      S_CFG_GAP: if (cnt == CNT_W'(GAP_CYCLES - 1)) state_next = S_IDLE;
      S_IDLE:    if (en) state_next = S_READ;
      S_READ:    if (xfer_done) state_next = S_PUBLISH;
      S_PUBLISH: state_next = S_WAIT;
      S_WAIT:    if (cnt == CNT_W'(POLL_CYCLES - 1)) state_next = en ? S_READ : S_IDLE;
      default:   state_next = S_CFG;
    endcase
    if ((phase == PH_OFF) && ((state_next == S_CFG) || (state_next == S_READ)))
      xfer_start = 1'b1;
    if (state_next == S_CFG)
      tx_load = {8'h20, CFG_BYTE, 40'h0};
  end

  // Dwell counter for CFG_GAP and WAIT; restarts on every state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      cnt <= '0;
    else if (state_next != state)                  cnt <= '0;
    else if ((state == S_CFG_GAP) || (state == S_WAIT)) cnt <= cnt + CNT_W'(1);
  end

  // SPI engine: setup, 8*N low/high bit periods, hold. mosi shifts only when
  // sclk falls between bits; miso is captured on the edge sclk rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase   <= PH_OFF;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
    end else if (phase == PH_OFF) begin
      if (xfer_start) begin
        phase   <= PH_SETUP;
        div_cnt <= '0;
        bit_cnt <= '0;
        tx_sh   <= tx_load;
        rx_sh   <= '0;
      end
    end else if (!div_last) begin
      div_cnt <= div_cnt + DIV_W'(1);
    end else begin
      div_cnt <= '0;
      case (phase)
        PH_SETUP: phase <= PH_LOW;
        PH_LOW: begin
          phase <= PH_HIGH;
          rx_sh <= {rx_sh[46:0], miso};
        end
        PH_HIGH: begin
          if (bit_last) begin
            phase <= PH_HOLD;
          end else begin
            phase   <= PH_LOW;
            bit_cnt <= bit_cnt + 6'd1;
            tx_sh   <= {tx_sh[54:0], 1'b0};
          end
        end
        default: phase <= PH_OFF;
      endcase
    end
  end

  // Axis registers load only from a completed read, in the same edge that
  // enters PUBLISH, so all three change together with data_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xAxis_gyro <= '0;
      yAxis_gyro <= '0;
      zAxis_gyro <= '0;
    end else if ((state == S_READ) && xfer_done) begin
      xAxis_gyro <= {rx_sh[39:32], rx_sh[47:40]};
      yAxis_gyro <= {rx_sh[23:16], rx_sh[31:24]};
      zAxis_gyro <= {rx_sh[7:0],   rx_sh[15:8]};
    end
  end

  assign ss         = (phase == PH_OFF);
  assign sclk       = (phase != PH_LOW);
  assign mosi       = (phase != PH_OFF) && tx_sh[55];
  assign busy       = (phase != PH_OFF);
  assign data_valid = (state == S_PUBLISH);
  assign state_dbg  = state;

endmodule

// File: tb/tb_gyro_spi_reader.sv
// Directed bench for gyro_spi_reader with a mode-3 PmodGyro slave model,
// a publish scoreboard and continuous SPI timing checks.
module tb_gyro_spi_reader;

  localparam int CLK_DIV = 2;
  localparam int POLL    = 10;
  localparam int TCLK    = 10;
  localparam longint EDGE_GAP = CLK_DIV * TCLK;

  logic        clk;
  logic        rst;
  logic        en;
  logic        miso;
  logic        sclk;
  logic        mosi;
  logic        ss;
  logic [15:0] x_axis;
  logic [15:0] y_axis;
  logic [15:0] z_axis;
  logic        data_valid;
  logic        busy;
  logic [2:0]  state_dbg;

  int n_assert = 0;
  int n_fail   = 0;

  gyro_spi_reader #(
    .CLK_DIV(CLK_DIV),
    .POLL_CYCLES(POLL),
    .CFG_BYTE(8'h0F)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .miso(miso),
    .sclk(sclk),
    .mosi(mosi),
    .ss(ss),
    .xAxis_gyro(x_axis),
    .yAxis_gyro(y_axis),
    .zAxis_gyro(z_axis),
    .data_valid(data_valid),
    .busy(busy),
    .state_dbg(state_dbg)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave model: records each transaction, answers burst reads from rsp_q.
  logic [47:0] rsp_q[$];
  logic [47:0] slv_rsp;
  logic [63:0] slv_mosi;
  int          slv_cnt;
  logic        slv_active = 1'b0;
  int          n_fall = 0;
  int          n_xfer = 0;
  int          rec_bits[0:15];
  logic [63:0] rec_mosi[0:15];
  longint      rec_fall[0:15];
  longint      rec_rise[0:15];

  initial miso = 1'b1;

  always @(negedge ss) begin
    rec_fall[n_xfer] = longint'($time);
    slv_cnt    = 0;
    slv_mosi   = '0;
    slv_rsp    = '0;
    slv_active = 1'b1;
    miso       = 1'b1;
    n_fall++;
  end

  always @(posedge sclk) begin
    if (slv_active && !ss) begin
      slv_mosi = {slv_mosi[62:0], mosi};
      slv_cnt++;
      if (slv_cnt == 8) begin
        if ((slv_mosi[7:0] == 8'hE8) && (rsp_q.size() > 0)) slv_rsp = rsp_q.pop_front();
        else slv_rsp = '0;
      end
    end
  end

  always @(negedge sclk) begin
    if (slv_active && !ss && (slv_cnt >= 8) && (slv_cnt < 56))
      miso = slv_rsp[47 - (slv_cnt - 8)];
  end

  always @(posedge ss) begin
    if (slv_active) begin
      rec_bits[n_xfer] = slv_cnt;
      rec_mosi[n_xfer] = slv_mosi;
      rec_rise[n_xfer] = longint'($time);
      n_xfer++;
      slv_active = 1'b0;
      miso = 1'b1;
    end
  end

  // SPI timing checks: edge spacing and mosi stability around sclk rises.
  longint t_ss   = -1000;
  longint t_sclk = -1000;
  longint t_rise = -1000;
  longint t_mosi = -1000;

  always @(ss) begin
    if (rst === 1'b1) check("ss_after_sclk_gap", 64'((longint'($time) - t_sclk) >= EDGE_GAP), 64'd1);
    t_ss = longint'($time);
  end

  always @(sclk) begin
    if (rst === 1'b1) begin
      check("sclk_after_ss_gap", 64'((longint'($time) - t_ss) >= EDGE_GAP), 64'd1);
      if (sclk === 1'b1) check("mosi_setup_before_rise", 64'((longint'($time) - t_mosi) >= EDGE_GAP), 64'd1);
    end
    t_sclk = longint'($time);
    if (sclk === 1'b1) t_rise = longint'($time);
  end

  always @(mosi) begin
    if (rst === 1'b1) check("mosi_hold_after_rise", 64'((longint'($time) - t_rise) >= EDGE_GAP), 64'd1);
    t_mosi = longint'($time);
  end

  always @(negedge clk) begin
    if ((rst === 1'b1) && (ss === 1'b1)) check("sclk_idle_high", 64'(sclk), 64'd1);
  end

  // Scoreboard: each publish must match the next expected {x,y,z}; between
  // publishes the outputs must hold the last expected value.
  logic [47:0] exp_q[$];
  logic [47:0] held = '0;
  logic [47:0] exp_v;
  logic        prev_dv = 1'b0;
  int          n_dv = 0;
  longint      dv_t[0:15];

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (data_valid === 1'b1) begin
        check("dv_single_pulse", 64'(prev_dv), 64'd0);
        dv_t[n_dv] = longint'($time) - 5;
        n_dv++;
        check("publish_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          exp_v = exp_q.pop_front();
          check("publish_xyz", {16'h0, x_axis, y_axis, z_axis}, {16'h0, exp_v});
          held = exp_v;
        end
      end else begin
        check("hold_xyz", {16'h0, x_axis, y_axis, z_axis}, {16'h0, held});
      end
    end
    prev_dv = data_valid;
  end

  task automatic wait_dv(input int target, input int max_cyc);
    int k = 0;
    while ((n_dv < target) && (k < max_cyc)) begin
      @(negedge clk); #1;
      k++;
    end
    check("wait_dv", 64'(n_dv >= target), 64'd1);
  endtask

  task automatic wait_xfer(input int target, input int max_cyc);
    int k = 0;
    while ((n_xfer < target) && (k < max_cyc)) begin
      @(negedge clk); #1;
      k++;
    end
    check("wait_xfer", 64'(n_xfer >= target), 64'd1);
  endtask

  task automatic wait_fall(input int target, input int max_cyc);
    int k = 0;
    while ((n_fall < target) && (k < max_cyc)) begin
      @(negedge clk); #1;
      k++;
    end
    check("wait_ss_fall", 64'(n_fall >= target), 64'd1);
  endtask

  // Directed sequence.
  initial begin
    rst = 1'b0;
    en  = 1'b1;
    rsp_q.push_back(48'h3412_CDAB_0080); exp_q.push_back(48'h1234_ABCD_8000);
    rsp_q.push_back(48'h0180_FF7F_55AA); exp_q.push_back(48'h8001_7FFF_AA55);
    rsp_q.push_back(48'hEFBE_ADDE_0DF0); exp_q.push_back(48'hBEEF_DEAD_F00D);
    rsp_q.push_back(48'h1122_3344_5566); exp_q.push_back(48'h2211_4433_6655);
    rsp_q.push_back(48'hAABB_CCDD_EEFF);

    // Reset values.
    repeat (3) @(negedge clk);
    #1;
    check("rst_ss", 64'(ss), 64'd1);
    check("rst_sclk", 64'(sclk), 64'd1);
    check("rst_mosi", 64'(mosi), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_dv", 64'(data_valid), 64'd0);
    check("rst_xyz", {16'h0, x_axis, y_axis, z_axis}, 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);

    // First ss fall on the first edge after release.
    rst = 1'b1;
    #1;
    check("rel_ss_high", 64'(ss), 64'd1);
    @(posedge clk); #1;
    check("first_edge_ss", 64'(ss), 64'd0);
    check("first_edge_busy", 64'(busy), 64'd1);

    // Configuration write.
    wait_xfer(1, 200);
    check("cfg_bits", 64'(rec_bits[0]), 64'd16);
    check("cfg_mosi", rec_mosi[0], 64'h200F);
    check("cfg_ss_low", 64'(rec_rise[0] - rec_fall[0]), 64'(68 * TCLK));

    // First read.
    wait_dv(1, 600);
    check("rd1_bits", 64'(rec_bits[1]), 64'd56);
    check("rd1_mosi", rec_mosi[1], 64'h00E8_0000_0000_0000);
    check("rd1_ss_low", 64'(rec_rise[1] - rec_fall[1]), 64'(228 * TCLK));
    check("cfg_gap_ss_high", 64'(rec_fall[1] - rec_rise[0]), 64'(5 * TCLK));
    check("rd1_x", 64'(x_axis), 64'h1234);
    check("rd1_y", 64'(y_axis), 64'hABCD);
    check("rd1_z", 64'(z_axis), 64'h8000);
    repeat (5) @(negedge clk);
    #1;
    check("rd1_one_dv", 64'(n_dv), 64'd1);

    // Back-to-back polling.
    wait_dv(3, 1000);
    check("poll_gap_1", 64'(rec_fall[2] - dv_t[0]), 64'(11 * TCLK));
    check("poll_gap_2", 64'(rec_fall[3] - dv_t[1]), 64'(11 * TCLK));
    check("rd3_x", 64'(x_axis), 64'hBEEF);
    check("rd3_z", 64'(z_axis), 64'hF00D);

    // en dropped during byte 3 of the fourth read.
    wait_fall(5, 100);
    check("poll_gap_3", 64'(rec_fall[4] - dv_t[2]), 64'(11 * TCLK));
    repeat (100) @(negedge clk);
    #1;
    en = 1'b0;
    wait_dv(4, 400);
    check("rd4_x", 64'(x_axis), 64'h2211);
    check("rd4_y", 64'(y_axis), 64'h4433);
    repeat (20) @(negedge clk);
    #1;
    check("idle_state", 64'(state_dbg), 64'd2);
    check("idle_ss", 64'(ss), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_no_fall", 64'(n_fall), 64'd5);
    repeat (10) @(negedge clk);
    #1;
    check("idle_still_no_fall", 64'(n_fall), 64'd5);

    // en re-raised: READ and ss fall on the next edge.
    en = 1'b1;
    @(posedge clk); #1;
    check("reraise_ss", 64'(ss), 64'd0);
    check("reraise_state", 64'(state_dbg), 64'd3);
    check("reraise_fall", 64'(n_fall), 64'd6);

    // Reset during byte 4 of the fifth read.
    repeat (134) @(negedge clk);
    #1;
    rst  = 1'b0;
    held = '0;
    #1;
    check("abort_ss", 64'(ss), 64'd1);
    check("abort_sclk", 64'(sclk), 64'd1);
    check("abort_mosi", 64'(mosi), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_dv", 64'(data_valid), 64'd0);
    check("abort_xyz", {16'h0, x_axis, y_axis, z_axis}, 64'd0);
    repeat (3) @(negedge clk);
    #1;
    check("abort_no_publish", 64'(n_dv), 64'd4);
    check("abort_recorded", 64'(n_xfer), 64'd6);
    check("abort_truncated", 64'(rec_bits[5] < 56), 64'd1);

    // Release: configuration is sent again, then polling resumes.
    rsp_q.push_back(48'h7856_3412_2143); exp_q.push_back(48'h5678_1234_4321);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rerun_first_edge_ss", 64'(ss), 64'd0);
    wait_xfer(7, 200);
    check("recfg_bits", 64'(rec_bits[6]), 64'd16);
    check("recfg_mosi", rec_mosi[6], 64'h200F);
    wait_dv(5, 600);
    check("rd6_x", 64'(x_axis), 64'h5678);
    check("rd6_y", 64'(y_axis), 64'h1234);
    check("rd6_z", 64'(z_axis), 64'h4321);

    en = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check("end_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("end_state_idle", 64'(state_dbg), 64'd2);
    check("end_dv_count", 64'(n_dv), 64'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
